// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
//   Shared definitions for the MAC sequencer and the MAC demo datapath:
//   default operand/address widths and the sequencer state encoding.
package mac_ctrl_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

endpackage

// File: rtl/mac_addr_gen.sv
// mac_addr_gen
//   Tap counter plus address generation for one dot-product run.
//   Ports:
//     clk, reset      clock, async active-low reset
//     load            restart the tap counter at 0 (run accepted)
//     step            advance the tap counter (a read was issued this cycle)
//     en              drive addresses; outside a read they are forced to 0
//     len_m1, x_base  run parameters, already latched by the caller
//     k_addr, x_addr  coefficient / circular sample addresses
//     last            current tap is the final one (i == len_m1)
import mac_ctrl_pkg::*;

module mac_addr_gen #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              en,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic [ADDR_W-1:0] x_base,
    output logic [ADDR_W-1:0] k_addr,
    output logic [ADDR_W-1:0] x_addr,
    output logic              last
);

    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] x_sum;

    always_comb begin
        i_d = i_q;
        if (load)      i_d = '0;
        else if (step) i_d = i_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) i_q <= '0;
        else        i_q <= i_d;
    end

    // ADDR_W-bit sum: the sample buffer wraps silently at 2^ADDR_W.
    assign x_sum  = x_base + i_q;
    assign last   = (i_q == len_m1);
    assign k_addr = en ? i_q   : '0;
    assign x_addr = en ? x_sum : '0;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Runs one length-N dot product on the shared MAC cell: clear, stream N
//   coefficient/sample pairs, capture the accumulator, hold it for the consumer.
//   Ports:
//     clk, reset                  clock, async active-low reset
//     start, len_m1, x_base       run request (taken only while ready)
//     ready, busy                 status
//     rd_en, k_addr, x_addr       memory read port (data one cycle later)
//     k_data, x_data              memory read data
//     mac_clr, mac_ena            MAC control
//     mac_k, mac_x                MAC operands (zero when not accumulating)
//     acc_in                      MAC accumulator
//     result, result_valid,
//     result_ready                result handshake
import mac_ctrl_pkg::*;

module mac_seq_ctrl #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    len_m1,
    input  logic [ADDR_W-1:0]    x_base,
    output logic                 ready,
    output logic                 busy,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    k_addr,
    output logic [ADDR_W-1:0]    x_addr,
    input  logic [WIDTH-1:0]     k_data,
    input  logic [WIDTH-1:0]     x_data,
    output logic                 mac_clr,
    output logic                 mac_ena,
    output logic [WIDTH-1:0]     mac_k,
    output logic [WIDTH-1:0]     mac_x,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   xb_q, xb_d;
    logic                mac_ena_q, mac_ena_d;
    logic [2*WIDTH-1:0]  result_q, result_d;
    logic                result_valid_q, result_valid_d;
    logic                accept;
    logic                last;

    assign accept  = (state_q == ST_IDLE) && start;
    assign ready   = (state_q == ST_IDLE);
    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HOLD);
    assign rd_en   = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign mac_clr = (state_q == ST_CLEAR);

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        xb_d           = xb_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len_m1;
                    xb_d    = x_base;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR:   state_d = (len_q != '0) ? ST_RUN : ST_DRAIN;
            ST_RUN:     if (last) state_d = ST_DRAIN;
            ST_DRAIN:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                // Final accumulate landed on the edge entering this state.
                result_d       = acc_in;
                result_valid_d = 1'b1;
                state_d        = ST_HOLD;
            end
            ST_HOLD: begin
                // start is not looked at here, so a coincident start is dropped.
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // Read data arrives one cycle after rd_en, so enable follows it by one.
    assign mac_ena_d = rd_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            xb_q           <= '0;
            mac_ena_q      <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            xb_q           <= xb_d;
            mac_ena_q      <= mac_ena_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    mac_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (rd_en),
        .en     (rd_en),
        .len_m1 (len_q),
        .x_base (xb_q),
        .k_addr (k_addr),
        .x_addr (x_addr),
        .last   (last)
    );

    assign mac_ena      = mac_ena_q;
    assign mac_k        = mac_ena_q ? k_data : '0;
    assign mac_x        = mac_ena_q ? x_data : '0;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

    localparam int W = 16;
    localparam int A = 6;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [A-1:0]   len_m1 = '0;
    logic [A-1:0]   x_base = '0;
    logic           ready, busy, rd_en, mac_clr, mac_ena, result_valid;
    logic [A-1:0]   k_addr, x_addr;
    logic [W-1:0]   k_data = '0, x_data = '0, mac_k, mac_x;
    logic [2*W-1:0] acc = '0, result;
    logic           result_ready = 1'b0;

    logic [W-1:0] k_mem [64];
    logic [W-1:0] x_mem [64];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len_m1(len_m1), .x_base(x_base),
        .ready(ready), .busy(busy), .rd_en(rd_en), .k_addr(k_addr), .x_addr(x_addr),
        .k_data(k_data), .x_data(x_data), .mac_clr(mac_clr), .mac_ena(mac_ena),
        .mac_k(mac_k), .mac_x(mac_x), .acc_in(acc), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    // Synchronous-read memories and a plain MAC cell as the environment.
    always @(posedge clk) begin
        if (rd_en) begin
            k_data <= k_mem[k_addr];
            x_data <= x_mem[x_addr];
        end
    end
    always @(posedge clk) begin
        if (mac_clr)      acc <= '0;
        else if (mac_ena) acc <= acc + ({16'b0, mac_k} * {16'b0, mac_x});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    localparam int P_SINGLE = 0, P_RAMP = 1, P_ONES = 2;

    task automatic fill(input int pat);
        for (int i = 0; i < 64; i++) begin
            case (pat)
                P_SINGLE: begin k_mem[i] = (i == 0) ? 16'd5 : 16'd0; x_mem[i] = (i == 0) ? 16'd1 : 16'd0; end
                P_RAMP:   begin k_mem[i] = 16'(i + 1); x_mem[i] = 16'(i + 5); end
                default:  begin k_mem[i] = 16'hFFFF; x_mem[i] = 16'hFFFF; end
            endcase
        end
    endtask

    logic [A-1:0] kq[$];
    logic [A-1:0] xq[$];

    // Issue one run and watch it until result_valid (or the cycle budget runs out).
    task automatic run(input logic [A-1:0] lm1, input logic [A-1:0] xb,
                       output logic [31:0] res, output int ena, output int lat,
                       output bit clr0, output int bad);
        @(negedge clk);
        start = 1'b1; len_m1 = lm1; x_base = xb;
        @(negedge clk);
        start = 1'b0;
        ena = 0; lat = -1; bad = 0; clr0 = 1'b0;
        kq.delete(); xq.delete();
        for (int c = 0; c < 200; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) clr0 = mac_clr && rd_en && (k_addr == 0) && !mac_ena;
            else if (mac_clr) bad++;
            if (mac_clr && mac_ena) bad++;
            if (mac_ena) ena++;
            if (rd_en) begin kq.push_back(k_addr); xq.push_back(x_addr); end
            if (result_valid) begin lat = c; break; end
        end
        res = result;
    endtask

    task automatic release_result(input string name);
        check({name, "_hold_status"}, {31'b0, ready | busy}, 32'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check({name, "_idle_after"}, {30'b0, ready, result_valid}, 32'b10);
    endtask

    typedef struct {
        string        name;
        logic [A-1:0] lm1;
        logic [A-1:0] xb;
        int           pat;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [31:0] res, held;
        int ena, lat, bad, viol;
        bit clr0;
        logic [A-1:0] exp_x[4];

        vecs[0] = '{"single", 6'd0,  6'd0,  P_SINGLE, 32'd5};
        vecs[1] = '{"four",   6'd3,  6'd0,  P_RAMP,   32'd70};
        vecs[2] = '{"circ",   6'd3,  6'd62, P_RAMP,   32'd242};   // 1*67+2*68+3*5+4*6
        vecs[3] = '{"two",    6'd1,  6'd63, P_RAMP,   32'd78};    // 1*68+2*5
        vecs[4] = '{"full",   6'd63, 6'd0,  P_ONES,   32'hFF800040};

        // Reset state
        #2;
        check("rst_outs", {ready, busy, rd_en, mac_clr, mac_ena, result_valid, k_addr, x_addr},
              {1'b1, 5'b0, 12'b0});
        check("rst_data", {mac_k, mac_x}, 32'd0);
        check("rst_result", result, 32'd0);
        #20 reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].pat);
            run(vecs[v].lm1, vecs[v].xb, res, ena, lat, clr0, bad);
            check({vecs[v].name, "_result"}, res, vecs[v].exp);
            check({vecs[v].name, "_ena_cycles"}, ena, 32'(vecs[v].lm1) + 1);
            check({vecs[v].name, "_latency"}, lat, 32'(vecs[v].lm1) + 3);
            check({vecs[v].name, "_clr_first"}, {31'b0, clr0}, 32'd1);
            check({vecs[v].name, "_clr_ena_overlap"}, bad, 32'd0);
            if (v == 2) begin
                exp_x = '{6'd62, 6'd63, 6'd0, 6'd1};
                check("circ_nreads", kq.size(), 32'd4);
                for (int i = 0; i < 4 && i < kq.size(); i++) begin
                    check($sformatf("circ_k_addr%0d", i), 32'(kq[i]), 32'(i));
                    check($sformatf("circ_x_addr%0d", i), 32'(xq[i]), 32'(exp_x[i]));
                end
            end
            if (v == 4) begin
                // Backpressure: 10 cycles of HOLD with a start pulse in the middle.
                held = result; viol = 0;
                for (int c = 0; c < 10; c++) begin
                    start = (c == 4);
                    @(negedge clk);
                    if (result !== held || !result_valid || ready || busy || rd_en || mac_clr ||
                        mac_k != 0) viol++;
                end
                start = 1'b0;
                check("bp_hold_stable", viol, 32'd0);
                // start together with result_ready: only result_ready is honoured.
                start = 1'b1; result_ready = 1'b1;
                @(negedge clk);
                start = 1'b0; result_ready = 1'b0;
                check("bp_release", {29'b0, ready, rd_en, result_valid}, 32'b100);
                check("bp_result_kept", result, held);
                @(negedge clk);
                check("bp_no_run", {30'b0, ready, busy}, 32'b10);
            end else begin
                release_result(vecs[v].name);
            end
        end

        // Fresh start after backpressure
        fill(P_RAMP);
        run(6'd3, 6'd0, res, ena, lat, clr0, bad);
        check("post_bp_result", res, 32'd70);
        release_result("post_bp");

        // Reset in the 5th RUN cycle of an N=16 run
        @(negedge clk);
        start = 1'b1; len_m1 = 6'd15; x_base = 6'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", {30'b0, busy, rd_en}, 32'b11);
        reset = 1'b0;
        #1;
        check("mid_rst_outs", {ready, busy, rd_en, mac_clr, mac_ena, result_valid, k_addr, x_addr},
              {1'b1, 5'b0, 12'b0});
        check("mid_rst_data", {mac_k, mac_x}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run(6'd3, 6'd0, res, ena, lat, clr0, bad);
        check("after_rst_result", res, 32'd70);
        check("after_rst_clr_first", {31'b0, clr0}, 32'd1);
        check("after_rst_ena", ena, 32'd4);
        release_result("after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
